shiftregister_framed: RTL
=========================

# shiftregister_framed

Parametrised, frame-aware successor to the basic serial/parallel shift register. It is full duplex: it shifts a word out on `serialDataOut` while shifting a word in on `serialDataIn`, with separate sample and launch edge indicators and a selectable MSB-first or LSB-first bit order. It counts bits within a chip-select style frame, delivers each completed received word with a one-cycle valid pulse, and flags frames that end on a partial word. It sits between the SPI-style peripheral edge generator and the register/FIFO logic.

## Interface
- `width`, default 8: word width in bits; must be ≥2.
- `CNTW`, default `$clog2(width+1)`: bit-counter width; derived, not overridden.

- `clk` in 1: FPGA clock; all state updates on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `sampleEdge` in 1: one-cycle pulse; capture `serialDataIn`.
- `launchEdge` in 1: one-cycle pulse; update `serialDataOut`.
- `frameActive` in 1: level; high = frame in progress (chip select).
- `lsbFirst` in 1: bit-order select; 1 = LSB first.
- `parallelLoad` in 1: load the shift register with `parallelDataIn`.
- `parallelDataIn` in width: word to transmit.
- `serialDataIn` in 1: serial receive data.
- `serialDataOut` out 1: serial transmit bit, registered.
- `parallelDataOut` out width: shift register contents, delayed one cycle.
- `rxData` out width: last completed received word; held until the next word completes.
- `rxValid` out 1: one-cycle pulse when `rxData` updates.
- `frameAbort` out 1: one-cycle pulse when a frame ends on a partial word.
- `busy` out 1: high while in the ACTIVE state.

## Operation
- Internal state:
  - `mem[width]`: the shift register.
  - `cnt[CNTW]`: bit counter.
  - `mode`: latched copy of `lsbFirst`.
  - `fa_q`: registered `frameActive`.
  - FSM with two states, IDLE and ACTIVE.
- Reset (`rst_n`=0 at a posedge): `mem`, `parallelDataOut`, `rxData`, `cnt` and `fa_q` are cleared to 0. `serialDataOut`, `rxValid`, `frameAbort`, `busy` and `mode` are cleared to 0. The FSM goes to IDLE. Reset overrides every other input.
- Frame start is `frameActive & ~fa_q`:
  - FSM goes to ACTIVE, `cnt` is cleared to 0, and `mode` is set to `lsbFirst`.
  - Because `fa_q` resets to 0, a `frameActive` held high through reset starts a frame on the first cycle after reset.
- Frame end is `~frameActive & fa_q`:
  - FSM goes to IDLE.
  - If `cnt`≠0: `frameAbort` pulses and `cnt` is cleared. `rxData` is unchanged and `rxValid` stays low.
- `parallelLoad` is accepted in any state:
  - `mem` is set to `parallelDataIn`.
  - `serialDataOut` is set to `parallelDataIn[0]` if `lsbFirst` is 1, else `parallelDataIn[width-1]`.
  - `mode` is set to `lsbFirst`.
  - Load has priority over both edge pulses in the same cycle. Those edges are dropped and `cnt` does not change.
- `sampleEdge` is acted on in ACTIVE only, and only when there is no load that cycle:
  - MSB first: `mem` becomes `{mem[width-2:0], serialDataIn}`.
  - LSB first: `mem` becomes `{serialDataIn, mem[width-1:1]}`.
  - `cnt` increments.
  - If `cnt` was `width-1`: `rxData` takes the post-shift `mem` value, `rxValid` pulses, and `cnt` wraps to 0. The FSM stays ACTIVE, so back-to-back words are allowed.
- `launchEdge` is acted on in ACTIVE only, and only when there is no load that cycle:
  - MSB first: `serialDataOut` takes `mem[width-1]`.
  - LSB first: `serialDataOut` takes `mem[0]`.
  - If `sampleEdge` is high in the same cycle, the launch uses the post-shift value: `mem[width-2]` for MSB first, `mem[1]` for LSB first.
- Both edge pulses are ignored in IDLE; `mem`, `cnt` and `serialDataOut` hold.
- A frame start and a frame end cannot occur in the same cycle. A frame start in the same cycle as `sampleEdge` clears `cnt` and the sample is ignored.
- `parallelDataOut` takes `mem` every cycle, so it lags `mem` by one cycle.

## Timing
- `rxValid` and the new `rxData` appear in the cycle after the posedge that accepted the completing `sampleEdge`.
- `serialDataOut` is valid in the cycle after a load or an accepted launch.
- `busy` rises in the cycle after the `frameActive` rising edge is sampled by `clk`, and falls in the cycle after the falling edge is sampled. Both transitions are registered.
- `frameAbort` appears in the same cycle that `busy` falls.
- Minimum spacing between edge pulses is one cycle; pulses may arrive on consecutive cycles.
- `rst_n` low mid-frame: all outputs read 0 in the following cycle and any partial word is discarded without `frameAbort`.

## Structure
- Shared package (or include) `shiftreg_pkg`:
  - State encodings `SR_IDLE`=1'b0 and `SR_ACTIVE`=1'b1.
  - Bit-order constants `SR_MSB_FIRST`=0 and `SR_LSB_FIRST`=1.
- Sub-module `frame_bit_counter` (parameter `width`):
  - Inputs: `clk`, `rst_n`, `clear`, `inc`.
  - Outputs: `cnt`, `wrap` (combinational: `inc` && `cnt`==`width-1`), `nonzero`.
- The shift datapath and the FSM stay in the top module.

## Test plan
- MSB first, `width`=8: load 0xA5, start frame, 8 sample+launch pairs with `serialDataIn` bits of 0x3C (MSB first) -> `serialDataOut` sequence 1,0,1,0,0,1,0,1, `rxData`=0x3C, exactly one `rxValid` pulse.
- LSB first: load 0x01 with `lsbFirst`=1, 8 pairs with `serialDataIn` 1,0,0,0,0,0,0,0 -> `serialDataOut` 1 then 0 ×7, `rxData`=0x01.
- Abort: `frameActive` drops after 5 samples -> one `frameAbort` pulse, no `rxValid`, `rxData` unchanged, `busy`=0; the next frame completes normally after 8 samples.
- Continuous frame: 16 samples carrying 0xF0 then 0x0F -> two `rxValid` pulses 8 samples apart, `rxData` 0xF0 then 0x0F.
- Collisions: `parallelLoad` with `sampleEdge` -> `mem`=`parallelDataIn` and `cnt` unchanged. Edges while IDLE -> `mem`, `cnt` and `serialDataOut` hold.
- `rst_n`=0 after 3 samples with `frameActive` held high -> all outputs 0 the next cycle; `busy` reasserts on the first cycle after reset deasserts and `cnt` starts from 0.

Source files
------------

// File: rtl/shiftreg_pkg.sv
// Shared definitions for the framed serial/parallel shift register.
package shiftreg_pkg;

  typedef enum logic {
    SR_IDLE   = 1'b0,
    SR_ACTIVE = 1'b1
  } srState_t;

  localparam logic SR_MSB_FIRST = 1'b0;
  localparam logic SR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/frame_bit_counter.sv
// Counts received bits within a frame and flags the bit that completes a word.
module frame_bit_counter #(
  parameter int width = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         inc,
  output logic [$clog2(width + 1)-1:0] cnt,
  output logic                         wrap,
  output logic                         nonzero
);

  localparam int              CNTW = $clog2(width + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(width - 1);

  assign wrap    = inc && (cnt == LAST);
  assign nonzero = (cnt != '0);

  // Clear beats increment; the bit that completes a word folds the count back to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNTW'(1);
    end
  end

endmodule

// File: rtl/shiftregister_framed.sv
// Full-duplex, frame-aware shift register with selectable bit order.
module shiftregister_framed
  import shiftreg_pkg::*;
#(
  parameter int width = 8,
  parameter int CNTW  = $clog2(width + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sampleEdge,
  input  logic             launchEdge,
  input  logic             frameActive,
  input  logic             lsbFirst,
  input  logic             parallelLoad,
  input  logic [width-1:0] parallelDataIn,
  input  logic             serialDataIn,
  output logic             serialDataOut,
  output logic [width-1:0] parallelDataOut,
  output logic [width-1:0] rxData,
  output logic             rxValid,
  output logic             frameAbort,
  output logic             busy
);

  srState_t         state;
  logic [width-1:0] mem;
  logic [width-1:0] shifted;
  logic [width-1:0] memAfterSample;
  logic             mode;
  logic             faQ;
  logic             frameStart;
  logic             frameEnd;
  logic             edgesEnabled;
  logic             doSample;
  logic             doLaunch;
  logic             launchBit;
  logic             loadBit;
  logic [CNTW-1:0]  bitCount;
  logic             wordDone;
  logic             partialWord;

  assign frameStart   = frameActive & ~faQ;
  assign frameEnd     = ~frameActive & faQ;
  assign edgesEnabled = (state == SR_ACTIVE) & ~parallelLoad & ~frameEnd;
  assign doSample     = edgesEnabled & sampleEdge;
  assign doLaunch     = edgesEnabled & launchEdge;
  assign busy         = (state == SR_ACTIVE);

  frame_bit_counter #(
    .width(width)
  ) bitCounter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (frameStart | frameEnd),
    .inc     (doSample),
    .cnt     (bitCount),
    .wrap    (wordDone),
    .nonzero (partialWord)
  );

  // Next register contents if a sample is taken, in the latched bit order.
  always_comb begin
    shifted = mem;
    if (mode == SR_MSB_FIRST) begin
      shifted = {mem[width-2:0], serialDataIn};
    end else begin
      shifted = {serialDataIn, mem[width-1:1]};
    end
  end

  // A launch coinciding with a sample drives the bit that the shift just exposed.
  always_comb begin
    memAfterSample = doSample ? shifted : mem;
    launchBit      = (mode == SR_MSB_FIRST) ? memAfterSample[width-1] : memAfterSample[0];
    loadBit        = (lsbFirst == SR_LSB_FIRST) ? parallelDataIn[0] : parallelDataIn[width-1];
  end

  // Shift datapath: load wins over both edges, and a completed word is published with a pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem             <= '0;
      serialDataOut   <= 1'b0;
      parallelDataOut <= '0;
      rxData          <= '0;
      rxValid         <= 1'b0;
    end else begin
      parallelDataOut <= mem;
      rxValid         <= 1'b0;
      if (parallelLoad) begin
        mem           <= parallelDataIn;
        serialDataOut <= loadBit;
      end else begin
        if (doSample) begin
          mem <= shifted;
        end
        if (doLaunch) begin
          serialDataOut <= launchBit;
        end
        if (wordDone) begin
          rxData  <= shifted;
          rxValid <= 1'b1;
        end
      end
    end
  end

  // Frame FSM: tracks chip select edges, latches bit order and flags frames ending mid-word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SR_IDLE;
      faQ        <= 1'b0;
      mode       <= SR_MSB_FIRST;
      frameAbort <= 1'b0;
    end else begin
      faQ        <= frameActive;
      frameAbort <= 1'b0;
      if (frameStart) begin
        state <= SR_ACTIVE;
      end else if (frameEnd) begin
        state      <= SR_IDLE;
        frameAbort <= partialWord;
      end
      if (parallelLoad || frameStart) begin
        mode <= lsbFirst;
      end
    end
  end

  // The counter's nonzero flag must agree with its count, which never reaches a full word.
  assert property (@(posedge clk) disable iff (!rst_n)
    (partialWord == (bitCount != '0)) && (bitCount < CNTW'(width)));

endmodule
